// File: rtl/router_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_fifo_pkg : shared 1x3 router constants and header-field helpers   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package router_fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int BYTE_WIDTH = 8;

    // Header byte layout: payload length in [7:2], destination in [1:0]
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    localparam int CNT_W = 7;

    typedef logic [LEN_MSB-LEN_LSB:0] pkt_len_t;
    typedef logic [CNT_W-1:0]         pkt_cnt_t;

    // Bytes still owed after a header: payload plus the trailing parity byte
    function automatic pkt_cnt_t bytes_owed(input pkt_len_t len);
        return {1'b0, len} + pkt_cnt_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_fifo_if : write/read/flush handshake of one router output FIFO    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface router_fifo_if
    import router_fifo_pkg::*;
#(
    parameter int WIDTH = BYTE_WIDTH
);
    logic             soft_rst;
    logic             we;
    logic             re;
    logic             lfd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             busy;

    modport master (
        output soft_rst, we, re, lfd, din,
        input  dout, full, empty, busy
    );

    modport slave (
        input  soft_rst, we, re, lfd, din,
        output dout, full, empty, busy
    );
endinterface
`default_nettype wire

// File: rtl/router_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_fifo_mem : DEPTH x DW storage, synchronous write, async read      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module router_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 9
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [DW-1:0]            wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output logic      [DW-1:0]            rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_fifo : per-destination tagged output FIFO with packet length cnt  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module router_fifo
    import router_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = BYTE_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       rst,
    router_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             r_lfd_q;
    pkt_cnt_t         r_cnt;
    logic [WIDTH-1:0] r_dout;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_mem_we;
    logic [WIDTH:0]   w_rd_word;

    // Pointers carry an extra wrap bit so full and empty stay distinguishable
    assign w_empty  = (r_wp == r_rp);
    assign w_full   = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign w_wr_ok  = bus.we && !w_full;
    assign w_rd_ok  = bus.re && !w_empty;
    assign w_mem_we = w_wr_ok && rst && !bus.soft_rst;

    router_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 1)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (r_wp[AW-1:0]),
        .wdata ({r_lfd_q, bus.din}),
        .raddr (r_rp[AW-1:0]),
        .rdata (w_rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_lfd_q <= 1'b0;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else if (bus.soft_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_lfd_q <= 1'b0;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else begin
            // din trails lfd by one cycle, so the delayed strobe tags the header
            r_lfd_q <= bus.lfd;
            if (w_wr_ok) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_ok) begin
                r_rp   <= r_rp + 1'b1;
                r_dout <= w_rd_word[WIDTH-1:0];
                if (w_rd_word[WIDTH]) begin
                    r_cnt <= bytes_owed(w_rd_word[LEN_MSB:LEN_LSB]);
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - pkt_cnt_t'(1);
                end
            end
        end
    end

    assign bus.dout  = r_dout;
    assign bus.full  = w_full;
    assign bus.empty = w_empty;
    assign bus.busy  = (r_cnt != '0);

endmodule
`default_nettype wire
